audio_dac_out: RTL and testbench

- Output stage directly downstream of the PSG mixer. Consumes the 8-bit clamped master sample that drives uo_out and produces a 1-bit audio stream for an external RC filter.
- Two modulation modes, selectable at runtime:
  - PWM with a period-synchronous sample latch (glitch-free duty updates).
  - First-order sigma-delta.
- Single clock domain, shared with the PSG core.

---
 rtl/psg_pkg.sv | 12 +
 rtl/audio_dac_out_if.sv | 25 ++
 rtl/sigma_delta_modulator.sv | 40 ++++
 rtl/audio_dac_out.sv | 92 +++++++++
 tb/tb_audio_dac_out.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/psg_pkg.sv
// Constants shared between the PSG mixer and its output stages.
// The master sample width and the DAC modulation mode encoding live here.
package psg_pkg;

  localparam int MASTER_OUTPUT_BITS = 8;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SDM = 1'b1
  } dac_mode_e;

endpackage

// File: rtl/audio_dac_out_if.sv
// Sample/control bundle between the mixer side and the audio DAC output stage.
// The master drives the sample and controls, and the slave returns the modulated bit.
interface audio_dac_out_if
  import psg_pkg::*;
#(
  parameter int VALUE_BITS = MASTER_OUTPUT_BITS
);

  logic                  enable;
  logic                  mode;
  logic [VALUE_BITS-1:0] value;
  logic                  out;
  logic                  sample_strobe;

  modport master (
    output enable, mode, value,
    input  out, sample_strobe
  );

  modport slave (
    input  enable, mode, value,
    output out, sample_strobe
  );

endinterface

// File: rtl/sigma_delta_modulator.sv
// First-order sigma-delta core. It holds the error accumulator and exposes the
// carry of acc + value, which the parent registers as the output bit.
module sigma_delta_modulator
  import psg_pkg::*;
#(
  parameter int VALUE_BITS = MASTER_OUTPUT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [VALUE_BITS-1:0] value,
  output logic                  carry
);

  logic [VALUE_BITS-1:0] acc_q, acc_d;
  logic [VALUE_BITS:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, value};
    carry = sum[VALUE_BITS];
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[VALUE_BITS-1:0];
    end
  end

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/audio_dac_out.sv
// 1-bit audio output stage: period-latched PWM or first-order sigma-delta,
// selected at runtime. A mode change clears the modulators for one edge.
module audio_dac_out
  import psg_pkg::*;
#(
  parameter int VALUE_BITS = MASTER_OUTPUT_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  audio_dac_out_if.slave bus
);

  // PWM counter runs 0..MAX, giving a period of 2^VALUE_BITS - 1 cycles.
  localparam logic [VALUE_BITS-1:0] MAX = {{(VALUE_BITS-1){1'b1}}, 1'b0};

  logic [VALUE_BITS-1:0] cnt_q, cnt_d;
  logic [VALUE_BITS-1:0] hold_q, hold_d;
  dac_mode_e             mode_r_q, mode_r_d;
  logic                  out_q, out_d;
  logic                  strobe_q, strobe_d;

  logic [VALUE_BITS-1:0] sel;
  logic                  mode_change;
  logic                  sdm_en;
  logic                  sdm_clr;
  logic                  sdm_carry;

  sigma_delta_modulator #(
    .VALUE_BITS (VALUE_BITS)
  ) u_sdm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sdm_en),
    .clr   (sdm_clr),
    .value (bus.value),
    .carry (sdm_carry)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    out_d       = out_q;
    strobe_d    = 1'b0;
    sdm_en      = 1'b0;
    sdm_clr     = 1'b0;
    mode_r_d    = dac_mode_e'(bus.mode);
    mode_change = (dac_mode_e'(bus.mode) != mode_r_q);
    sel         = (cnt_q == '0) ? bus.value : hold_q;

    // A mode change takes priority over enable and performs no modulation step.
    if (mode_change) begin
      cnt_d   = '0;
      out_d   = 1'b0;
      sdm_clr = 1'b1;
    end else if (bus.enable) begin
      if (mode_r_q == MODE_PWM) begin
        if (cnt_q == '0) begin
          hold_d   = bus.value;
          strobe_d = 1'b1;
        end
        out_d = (sel > cnt_q);
        cnt_d = (cnt_q == MAX) ? '0 : cnt_q + VALUE_BITS'(1);
      end else begin
        sdm_en   = 1'b1;
        out_d    = sdm_carry;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      mode_r_q <= MODE_PWM;
      out_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      mode_r_q <= mode_r_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.out           = out_q;
  assign bus.sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_dac_out.sv
// Directed bench for audio_dac_out: PWM periods, mid-period value changes,
// enable gaps, sigma-delta patterns, mode toggles and asynchronous reset.
module tb_audio_dac_out;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  audio_dac_out_if #(.VALUE_BITS(8)) bus ();

  audio_dac_out #(.VALUE_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog expired");
  end

  // Expected PWM out pattern for one period: v highs starting at offset 0.
  function automatic logic [254:0] pwm_mask(input int v);
    logic [254:0] one;
    one = 1;
    return (one << v) - one;
  endfunction

  // Records out/strobe after each of 255 edges; optionally changes value after edge chg_at.
  task automatic capture_period(input int chg_at, input logic [7:0] chg_val,
                                output logic [254:0] ov, output logic [254:0] sv);
    for (int k = 0; k < 255; k++) begin
      @(posedge clk);
      #1;
      ov[k] = bus.out;
      sv[k] = bus.sample_strobe;
      if (k == chg_at) bus.value = chg_val;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.mode   = 1'b0;
    bus.value  = 8'd0;
    #23;
    n_checks++;
    if (bus.out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got %b, required 0", bus.out);
    end
    n_checks++;
    if (bus.sample_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe: got %b, required 0", bus.sample_strobe);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pwm_const();
    logic [254:0] ov, sv;
    // value 0 for three periods; 255 is presented mid third period and must be ignored there
    for (int p = 0; p < 3; p++) begin
      capture_period((p == 2) ? 100 : -1, 8'd255, ov, sv);
      n_checks++;
      if (ov !== '0) begin
        n_fail++;
        $display("FAIL pwm0_out p%0d: got %h, required 0", p, ov);
      end
      n_checks++;
      if (sv !== 255'd1) begin
        n_fail++;
        $display("FAIL pwm0_strobe p%0d: got %h, required 1", p, sv);
      end
    end
    for (int p = 0; p < 3; p++) begin
      capture_period(-1, 8'd0, ov, sv);
      n_checks++;
      if (ov !== pwm_mask(255)) begin
        n_fail++;
        $display("FAIL pwm255_out p%0d: got %h, required all ones", p, ov);
      end
      n_checks++;
      if (sv !== 255'd1) begin
        n_fail++;
        $display("FAIL pwm255_strobe p%0d: got %h, required 1", p, sv);
      end
    end
  endtask

  task automatic test_pwm_value_change();
    logic [254:0] ov, sv;
    logic [7:0]   exp_v [3];
    exp_v[0] = 8'd64;
    exp_v[1] = 8'd64;
    exp_v[2] = 8'd200;
    bus.value = 8'd64;
    for (int p = 0; p < 3; p++) begin
      capture_period((p == 1) ? 100 : -1, 8'd200, ov, sv);
      n_checks++;
      if (ov !== pwm_mask(int'(exp_v[p]))) begin
        n_fail++;
        $display("FAIL pwm_change_out p%0d: got %h, required %h", p, ov, pwm_mask(int'(exp_v[p])));
      end
      n_checks++;
      if (sv !== 255'd1) begin
        n_fail++;
        $display("FAIL pwm_change_strobe p%0d: got %h, required 1", p, sv);
      end
    end
  endtask

  task automatic test_enable_gap();
    int highs, strobes, gap_err;
    logic first_strobe;
    highs = 0; strobes = 0; gap_err = 0; first_strobe = 1'b0;
    bus.value = 8'd100;
    // edges 31..40 are disabled; 255 enabled edges make one full period
    for (int i = 0; i < 265; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) first_strobe = bus.sample_strobe;
      if (bus.sample_strobe) strobes++;
      if (i >= 31 && i <= 40) begin
        if (bus.out !== 1'b1 || bus.sample_strobe !== 1'b0) gap_err++;
      end else if (bus.out === 1'b1) begin
        highs++;
      end
      if (i == 30) bus.enable = 1'b0;
      if (i == 40) bus.enable = 1'b1;
    end
    n_checks++;
    if (gap_err !== 0) begin
      n_fail++;
      $display("FAIL gap_frozen: got %0d bad gap cycles, required 0", gap_err);
    end
    n_checks++;
    if (highs !== 100) begin
      n_fail++;
      $display("FAIL gap_highs: got %0d, required 100", highs);
    end
    n_checks++;
    if (strobes !== 1 || first_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_strobe: got %0d strobes (first %b), required 1 at period start", strobes, first_strobe);
    end
  endtask

  task automatic test_mode_toggle();
    logic [7:0]   ob, sb;
    logic [254:0] ov, sv;
    for (int k = 0; k <= 50; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.out !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_pre_out: got %b, required 1", bus.out);
    end
    bus.mode  = 1'b1;
    bus.value = 8'd128;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out !== 1'b0 || bus.sample_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_sdm_edge: got out=%b strobe=%b, required 0/0", bus.out, bus.sample_strobe);
    end
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      ob[j] = bus.out;
      sb[j] = bus.sample_strobe;
    end
    n_checks++;
    if (ob !== 8'b1010_1010) begin
      n_fail++;
      $display("FAIL sdm128_out: got %b, required 10101010", ob);
    end
    n_checks++;
    if (sb !== 8'hFF) begin
      n_fail++;
      $display("FAIL sdm128_strobe: got %b, required 11111111", sb);
    end
    bus.value = 8'd64;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      ob[j] = bus.out;
    end
    n_checks++;
    if (ob !== 8'b1000_1000) begin
      n_fail++;
      $display("FAIL sdm64_out: got %b, required 10001000", ob);
    end
    bus.enable = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out !== 1'b1 || bus.sample_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL sdm_freeze c%0d: got out=%b strobe=%b, required 1/0", j, bus.out, bus.sample_strobe);
      end
    end
    // back to PWM with enable low on the same edge: the mode change still clears out
    bus.mode = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out !== 1'b0 || bus.sample_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_pwm_edge: got out=%b strobe=%b, required 0/0", bus.out, bus.sample_strobe);
    end
    bus.enable = 1'b1;
    capture_period(-1, 8'd0, ov, sv);
    n_checks++;
    if (ov !== pwm_mask(64) || sv !== 255'd1) begin
      n_fail++;
      $display("FAIL toggle_pwm_restart: got out=%h strobe=%h, required out=%h strobe=1", ov, sv, pwm_mask(64));
    end
  endtask

  task automatic test_async_reset();
    logic [254:0] ov, sv;
    bus.value = 8'd200;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out !== 1'b1 || bus.sample_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got out=%b strobe=%b, required 1/1", bus.out, bus.sample_strobe);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out !== 1'b0 || bus.sample_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_drop: got out=%b strobe=%b, required 0/0", bus.out, bus.sample_strobe);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out !== 1'b0 || bus.sample_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_held: got out=%b strobe=%b, required 0/0", bus.out, bus.sample_strobe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture_period(-1, 8'd0, ov, sv);
    n_checks++;
    if (ov !== pwm_mask(200) || sv !== 255'd1) begin
      n_fail++;
      $display("FAIL arst_restart: got out=%h strobe=%h, required out=%h strobe=1", ov, sv, pwm_mask(200));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_pwm_const();
    test_pwm_value_change();
    test_enable_gap();
    test_mode_toggle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
